// File: rtl/spi_cmd_regfile.sv
// ============================================================================
// Module   : spi_cmd_regfile
// Purpose  : Decodes 32-bit SPI command frames, executes register reads and
//            writes on the analog front-end control file, and hands a 32-bit
//            response back to the SPI slave for shifting out on the next frame.
//            Optional build macro CMD_PARITY_EN enables even parity checking
//            over the whole frame (parity bit carried in frame[23]).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_regfile #(
  parameter logic [15:0] ID_VALUE         = 16'h0180,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] tx_data_o,
  output logic        tx_wren_o,
  input  logic        tx_ack_i,
  input  logic        comp_i,
  input  logic        sat_hi_i,
  input  logic        sat_lo_i,
  input  logic        ref_ok_i,
  output logic [1:0]  afe_sel_o,
  output logic [2:0]  range_sel_o,
  output logic        ref_sign_o,
  output logic        afe_reset_o,
  output logic        err_o,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_LOAD   = 2'd2
  } state_e;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_CTRL    = 7'h01;
  localparam logic [6:0] ADDR_STATUS  = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH = 7'h03;
  localparam logic [7:0] RST_CNT_LOAD = 8'(RST_PULSE_CYCLES);

  // Registered state
  state_e      state_q,      state_d;
  logic [31:0] frame_q,      frame_d;
  logic [31:0] tx_data_q,    tx_data_d;
  logic        tx_wren_q,    tx_wren_d;
  logic [5:0]  ctrl_q,       ctrl_d;
  logic [15:0] scratch_q,    scratch_d;
  logic        sat_hi_seen_q, sat_hi_seen_d;
  logic        sat_lo_seen_q, sat_lo_seen_d;
  logic        overrun_q,    overrun_d;
  logic        bad_cmd_q,    bad_cmd_d;
  logic [7:0]  rst_cnt_q,    rst_cnt_d;
  logic        afe_reset_q,  afe_reset_d;
  logic        err_q,        err_d;

  // Frame decode
  logic        is_wr;
  logic [6:0]  addr;
  logic [15:0] wdata;
  logic        parity_err;
  logic        addr_err;
  logic        cmd_err;
  logic        in_decode;
  logic        do_write;
  logic [3:0]  w1c;
  logic [7:0]  status_cur;
  logic [7:0]  status_nxt;
  logic [15:0] rdata;
  logic [31:0] resp;

  assign is_wr = frame_q[31];
  assign addr  = frame_q[30:24];
  assign wdata = frame_q[15:0];

`ifdef CMD_PARITY_EN
  // Whole frame must XOR to zero; frame[23] carries the even-parity bit.
  assign parity_err = ^frame_q;
`else
  // Reserved byte carries no meaning in this build.
  logic unused_reserved;
  assign unused_reserved = ^frame_q[23:16];
  assign parity_err      = 1'b0;
`endif

  assign addr_err  = (addr[6:2] != 5'd0);
  assign cmd_err   = addr_err | parity_err;
  assign in_decode = (state_q == ST_DECODE);
  assign do_write  = in_decode & is_wr & ~cmd_err;
  assign w1c       = (do_write && addr == ADDR_STATUS) ? wdata[7:4] : 4'd0;

  assign status_cur = {bad_cmd_q, overrun_q, sat_lo_seen_q, sat_hi_seen_q,
                       ref_ok_i, sat_lo_i, sat_hi_i, comp_i};

  // Register file updates, sticky flags and the reset pulse counter
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    rst_cnt_d = (rst_cnt_q != 8'd0) ? (rst_cnt_q - 8'd1) : 8'd0;

    if (do_write && addr == ADDR_CTRL) begin
      ctrl_d = wdata[5:0];
      if (wdata[6]) begin
        rst_cnt_d = RST_CNT_LOAD;
      end
    end
    if (do_write && addr == ADDR_SCRATCH) begin
      scratch_d = wdata;
    end

    // A set on the same cycle as a W1C wins, so no event is ever lost.
    sat_hi_seen_d = sat_hi_i | (sat_hi_seen_q & ~w1c[0]);
    sat_lo_seen_d = sat_lo_i | (sat_lo_seen_q & ~w1c[1]);
    overrun_d     = (rx_valid_i && state_q != ST_IDLE) | (overrun_q & ~w1c[2]);
    bad_cmd_d     = (in_decode & cmd_err) | (bad_cmd_q & ~w1c[3]);

    afe_reset_d = (rst_cnt_d != 8'd0);
    err_d       = overrun_d | bad_cmd_d;
  end

  // Response word: reads see current state, writes see the post-write value
  always_comb begin
    status_nxt = {bad_cmd_d, overrun_d, sat_lo_seen_d, sat_hi_seen_d,
                  ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
    rdata = 16'd0;
    if (!cmd_err) begin
      case (addr)
        ADDR_ID:      rdata = ID_VALUE;
        ADDR_CTRL:    rdata = {10'd0, ctrl_d};
        ADDR_STATUS:  rdata = {8'd0, (is_wr ? status_nxt : status_cur)};
        ADDR_SCRATCH: rdata = scratch_d;
        default:      rdata = 16'd0;
      endcase
    end
    resp = {cmd_err, addr, status_cur, rdata};
  end

  // Command sequencer: capture, decode, then hold the response until accepted
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    tx_data_d = tx_data_q;
    tx_wren_d = tx_wren_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          frame_d = rx_data_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        tx_data_d = resp;
        if (rx_valid_i) begin
          // Newer frame supersedes the one being decoded; its response is dropped.
          frame_d   = rx_data_i;
          state_d   = ST_DECODE;
          tx_wren_d = 1'b0;
        end else begin
          state_d   = ST_LOAD;
          tx_wren_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (rx_valid_i) begin
          frame_d   = rx_data_i;
          state_d   = ST_DECODE;
          tx_wren_d = 1'b0;
        end else if (tx_ack_i) begin
          state_d   = ST_IDLE;
          tx_wren_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_wren_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      frame_q       <= 32'd0;
      tx_data_q     <= 32'd0;
      tx_wren_q     <= 1'b0;
      ctrl_q        <= 6'd0;
      scratch_q     <= 16'd0;
      sat_hi_seen_q <= 1'b0;
      sat_lo_seen_q <= 1'b0;
      overrun_q     <= 1'b0;
      bad_cmd_q     <= 1'b0;
      rst_cnt_q     <= 8'd0;
      afe_reset_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      tx_data_q     <= tx_data_d;
      tx_wren_q     <= tx_wren_d;
      ctrl_q        <= ctrl_d;
      scratch_q     <= scratch_d;
      sat_hi_seen_q <= sat_hi_seen_d;
      sat_lo_seen_q <= sat_lo_seen_d;
      overrun_q     <= overrun_d;
      bad_cmd_q     <= bad_cmd_d;
      rst_cnt_q     <= rst_cnt_d;
      afe_reset_q   <= afe_reset_d;
      err_q         <= err_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_wren_o   = tx_wren_q;
  assign afe_sel_o   = ctrl_q[1:0];
  assign range_sel_o = ctrl_q[4:2];
  assign ref_sign_o  = ctrl_q[5];
  assign afe_reset_o = afe_reset_q;
  assign err_o       = err_q;
  assign state_dbg_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_regfile.sv
// ============================================================================
// Module   : tb_spi_cmd_regfile
// Purpose  : Self-checking bench for spi_cmd_regfile (default build, parity
//            checking disabled). Table of frames plus hand-written sequences
//            for latency, reset pulse, sticky flags, overrun and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic [31:0] tx_data_o;
  logic        tx_wren_o;
  logic        tx_ack_i;
  logic        comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
  logic [1:0]  afe_sel_o;
  logic [2:0]  range_sel_o;
  logic        ref_sign_o;
  logic        afe_reset_o;
  logic        err_o;
  logic [1:0]  state_dbg_o;

  int checks = 0;
  int errors = 0;
  logic ack_en = 1'b1;
  logic [31:0] exp_q[$];

  spi_cmd_regfile #(.ID_VALUE(16'h0180), .RST_PULSE_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_wren_o(tx_wren_o), .tx_ack_i(tx_ack_i),
    .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i),
    .afe_sel_o(afe_sel_o), .range_sel_o(range_sel_o), .ref_sign_o(ref_sign_o),
    .afe_reset_o(afe_reset_o), .err_o(err_o), .state_dbg_o(state_dbg_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] frame;
    logic [31:0] resp;
    logic        err;
    logic [5:0]  ctrl;   // {ref_sign, range_sel, afe_sel}
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Acknowledge side of the SPI slave and scoreboard compare on each accepted load
  always @(negedge clk_i) begin
    tx_ack_i = ack_en && tx_wren_o;
    if (tx_wren_o && tx_ack_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", tx_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (tx_data_o !== e) begin
          errors++;
          $display("FAIL sb_resp: got %h expected %h", tx_data_o, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] frame);
    @(posedge clk_i); #1;
    rx_data_i  = frame;
    rx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_wren_o) && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got queue=%0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic xact(input string name, input logic [31:0] frame, input logic [31:0] resp);
    exp_q.push_back(resp);
    send(frame);
    drain(name);
  endtask

  initial begin
    int plen;
    vecs[0]  = '{32'h0000_0000, 32'h0008_0180, 1'b0, 6'h00};
    vecs[1]  = '{32'h8100_002D, 32'h0108_002D, 1'b0, 6'h2D};
    vecs[2]  = '{32'h0100_0000, 32'h0108_002D, 1'b0, 6'h2D};
    vecs[3]  = '{32'h8300_BEEF, 32'h0308_BEEF, 1'b0, 6'h2D};
    vecs[4]  = '{32'h0300_0000, 32'h0308_BEEF, 1'b0, 6'h2D};
    vecs[5]  = '{32'h03A5_0000, 32'h0308_BEEF, 1'b0, 6'h2D};
    vecs[6]  = '{32'h0200_0000, 32'h0208_0008, 1'b0, 6'h2D};
    vecs[7]  = '{32'h0400_0000, 32'h8408_0000, 1'b1, 6'h2D};
    vecs[8]  = '{32'h0200_0000, 32'h0288_0088, 1'b1, 6'h2D};
    vecs[9]  = '{32'h8200_0080, 32'h0288_0008, 1'b0, 6'h2D};
    vecs[10] = '{32'h0200_0000, 32'h0208_0008, 1'b0, 6'h2D};
    vecs[11] = '{32'h7F00_0000, 32'hFF08_0000, 1'b1, 6'h2D};
    vecs[12] = '{32'h8200_0080, 32'h0288_0008, 1'b0, 6'h2D};
    vecs[13] = '{32'h8100_0000, 32'h0108_0000, 1'b0, 6'h00};

    rst_ni = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; tx_ack_i = 1'b0;
    comp_i = 1'b0; sat_hi_i = 1'b0; sat_lo_i = 1'b0; ref_ok_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_tx_data", tx_data_o, 32'h0);
    chk("reset_outs", {22'd0, tx_wren_o, afe_sel_o, range_sel_o, ref_sign_o,
                       afe_reset_o, err_o, state_dbg_o}, 32'h0);

    // Table-driven frames, each run to completion
    for (int i = 0; i < 14; i++) begin
      xact($sformatf("vec%0d", i), vecs[i].frame, vecs[i].resp);
      chk($sformatf("vec%0d_err", i), {31'd0, err_o}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_ctrl", i), {26'd0, ref_sign_o, range_sel_o, afe_sel_o},
          {26'd0, vecs[i].ctrl});
    end

    // Latency and afe_reset pulse width
    exp_q.push_back(32'h0108_0000);
    send(32'h8100_0040);
    @(negedge clk_i);
    chk("lat_n1_state", {30'd0, state_dbg_o}, 32'd1);
    chk("lat_n1_wren_rst", {30'd0, tx_wren_o, afe_reset_o}, 32'd0);
    @(negedge clk_i);
    chk("lat_n2_wren_rst", {30'd0, tx_wren_o, afe_reset_o}, 32'd3);
    plen = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (afe_reset_o) plen++;
      else break;
    end
    chk("rst_pulse_len", plen, 32'd16);
    drain("pulse");

    // Sticky sat_hi, W1C, and set-over-clear priority on sat_lo
    @(posedge clk_i); #1 sat_hi_i = 1'b1;
    @(posedge clk_i); #1 sat_hi_i = 1'b0;
    xact("sat_hi_read", 32'h0200_0000, 32'h0218_0018);
    xact("sat_hi_w1c", 32'h8200_0010, 32'h0218_0008);
    @(posedge clk_i); #1 sat_lo_i = 1'b1;
    xact("sat_lo_w1c_held", 32'h8200_0020, 32'h022C_002C);
    @(posedge clk_i); #1 sat_lo_i = 1'b0;
    xact("sat_lo_w1c", 32'h8200_0020, 32'h0228_0008);

    // Overrun: first response held unacked, then superseded
    @(posedge clk_i); #1 ack_en = 1'b0;
    send(32'h0000_0000);
    repeat (3) @(negedge clk_i);
    chk("hold_wren", {31'd0, tx_wren_o}, 32'd1);
    chk("hold_data", tx_data_o, 32'h0008_0180);
    exp_q.push_back(32'h0348_BEEF);
    send(32'h0300_0000);
    @(negedge clk_i);
    chk("ovr_dropped", {29'd0, tx_wren_o, state_dbg_o}, 32'd1);
    @(posedge clk_i); #1 ack_en = 1'b1;
    drain("ovr");
    chk("ovr_err", {31'd0, err_o}, 32'd1);
    xact("ovr_clear", 32'h8200_0040, 32'h0248_0008);
    chk("ovr_err_clr", {31'd0, err_o}, 32'd0);

    // Asynchronous reset during an active pulse
    xact("prerst", 32'h8100_0041, 32'h0108_0001);
    chk("prerst_pulse", {31'd0, afe_reset_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_outs", {22'd0, tx_wren_o, afe_sel_o, range_sel_o, ref_sign_o,
                           afe_reset_o, err_o, state_dbg_o}, 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    xact("post_rst_scratch", 32'h0300_0000, 32'h0308_0000);
    xact("post_rst_ctrl", 32'h0100_0000, 32'h0108_0000);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
